// File: rtl/baud_pkg.sv
// Shared constants for the baud generator: reset divisor, oversampling limits,
// standard 50 MHz divisors and a constant-function ceil(log2) helper.
package baud_pkg;

    localparam int unsigned DEF_DIV = 27;

    localparam int unsigned OSR_MIN = 4;
    localparam int unsigned OSR_MAX = 32;

    // 50 MHz reference, OSR = 16, FRAC = 4: integer and 1/16 fractional parts
    localparam int unsigned DIV_50M_9600_INT    = 325;
    localparam int unsigned DIV_50M_9600_FRAC   = 8;
    localparam int unsigned DIV_50M_115200_INT  = 27;
    localparam int unsigned DIV_50M_115200_FRAC = 2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        int unsigned span;
        width = 0;
        span  = 1;
        while (span < value) begin
            span  = span << 1;
            width = width + 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/baud_frac_acc.sv
// Fractional-divisor accumulator: adds the fraction at each period end and
// flags a carry so the following period is stretched by one clock.
module baud_frac_acc #(
    parameter int FRAC = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [FRAC-1:0] i_add,
    input  logic            i_clear,
    input  logic            i_step,
    output logic            o_extend
);

    logic [FRAC-1:0] acc;
    logic [FRAC:0]   sum;

    always_comb begin
        sum      = {1'b0, acc} + {1'b0, i_add};
        o_extend = sum[FRAC];
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            acc <= '0;
        end else if (i_clear) begin
            acc <= '0;
        end else if (i_step) begin
            acc <= sum[FRAC-1:0];
        end
    end

endmodule

// File: rtl/baud_gen.sv
// Fractional baud-rate generator: sample-period down-counter, oversampling
// counter with mid/end-of-bit ticks, shadowed divisor load and phase resync.
module baud_gen #(
    parameter int WIDTH   = 16,
    parameter int FRAC    = 4,
    parameter int OSR     = 16,
    parameter int DEF_DIV = baud_pkg::DEF_DIV
) (
    input  logic                               i_clk,
    input  logic                               i_rst,
    input  logic                               i_en,
    input  logic [WIDTH-1:0]                   i_div_int,
    input  logic [((FRAC > 0) ? FRAC : 1)-1:0] i_div_frac,
    input  logic                               i_div_load,
    input  logic                               i_sync,
    output logic                               o_sample_tick,
    output logic                               o_mid_tick,
    output logic                               o_bit_tick,
    output logic                               o_div_ack
);

    import baud_pkg::*;

    localparam int FW  = (FRAC > 0) ? FRAC : 1;
    localparam int SCW = int'(clog2(OSR));

    localparam logic [WIDTH-1:0] RST_INT = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] RST_CNT = (DEF_DIV <= 1) ? '0 : WIDTH'(DEF_DIV - 1);
    localparam logic [SCW-1:0]   SC_MID  = SCW'(OSR / 2 - 1);
    localparam logic [SCW-1:0]   SC_LAST = SCW'(OSR - 1);

    logic [WIDTH-1:0] act_int;
    logic [FW-1:0]    act_frac;
    logic [WIDTH-1:0] sh_int;
    logic [FW-1:0]    sh_frac;
    logic             pending;
    logic [WIDTH-1:0] cnt;
    logic [SCW-1:0]   sc;

    logic [WIDTH-1:0] nxt_sh_int;
    logic [FW-1:0]    nxt_sh_frac;
    logic [WIDTH-1:0] use_int;
    logic [FW-1:0]    use_frac;
    logic [WIDTH-1:0] eff_int;
    logic [WIDTH-1:0] base;
    logic             pend_any;
    logic             period_end;
    logic             apply;
    logic             extend;

    // A load strobe coinciding with the apply point is folded into the
    // applied value, so back-to-back loads still yield a single ack.
    always_comb begin
        nxt_sh_int  = i_div_load ? i_div_int  : sh_int;
        nxt_sh_frac = i_div_load ? i_div_frac : sh_frac;
        pend_any    = pending | i_div_load;
        period_end  = i_en && (cnt == '0);
        apply       = (pend_any && (i_sync || period_end)) || (pending && !i_en);
        use_int     = apply ? nxt_sh_int  : act_int;
        use_frac    = apply ? nxt_sh_frac : act_frac;
        eff_int     = (use_int <= WIDTH'(1)) ? WIDTH'(1) : use_int;
        base        = eff_int - WIDTH'(1);
    end

    generate
        if (FRAC > 0) begin : g_frac
            baud_frac_acc #(
                .FRAC(FRAC)
            ) u_frac_acc (
                .i_clk   (i_clk),
                .i_rst   (i_rst),
                .i_add   (use_frac),
                .i_clear (i_sync),
                .i_step  (period_end && !i_sync),
                .o_extend(extend)
            );
        end else begin : g_no_frac
            assign extend = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            act_int       <= RST_INT;
            act_frac      <= '0;
            sh_int        <= RST_INT;
            sh_frac       <= '0;
            pending       <= 1'b0;
            cnt           <= RST_CNT;
            sc            <= '0;
            o_sample_tick <= 1'b0;
            o_mid_tick    <= 1'b0;
            o_bit_tick    <= 1'b0;
            o_div_ack     <= 1'b0;
        end else begin
            o_sample_tick <= 1'b0;
            o_mid_tick    <= 1'b0;
            o_bit_tick    <= 1'b0;
            o_div_ack     <= apply;
            sh_int        <= nxt_sh_int;
            sh_frac       <= nxt_sh_frac;
            pending       <= pend_any && !apply;
            if (apply) begin
                act_int  <= nxt_sh_int;
                act_frac <= nxt_sh_frac;
            end
            if (i_sync) begin
                cnt <= base;
                sc  <= '0;
            end else if (period_end) begin
                cnt           <= base + WIDTH'(extend);
                o_sample_tick <= 1'b1;
                o_mid_tick    <= (sc == SC_MID);
                o_bit_tick    <= (sc == SC_LAST);
                sc            <= (sc == SC_LAST) ? '0 : sc + SCW'(1);
            end else if (i_en) begin
                cnt <= cnt - WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_baud_gen.sv
// Self-checking bench for baud_gen: expected tick times come from closed-form
// period arithmetic and are compared cycle by cycle against recorded outputs.
module tb_baud_gen;

    localparam int WIDTH   = 16;
    localparam int FRAC    = 4;
    localparam int OSR     = 16;
    localparam int DEF_DIV = 27;
    localparam int FSCALE  = 1 << FRAC;
    localparam int MAXC    = 12000;
    localparam int NEVER   = 32'h3fff_ffff;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] div_int;
    logic [FRAC-1:0]  div_frac;
    logic             load;
    logic             sync;
    logic             o_sample_tick;
    logic             o_mid_tick;
    logic             o_bit_tick;
    logic             o_div_ack;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic s_hist [MAXC];
    logic m_hist [MAXC];
    logic b_hist [MAXC];
    logic a_hist [MAXC];

    baud_gen #(
        .WIDTH  (WIDTH),
        .FRAC   (FRAC),
        .OSR    (OSR),
        .DEF_DIV(DEF_DIV)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_div_int    (div_int),
        .i_div_frac   (div_frac),
        .i_div_load   (load),
        .i_sync       (sync),
        .o_sample_tick(o_sample_tick),
        .o_mid_tick   (o_mid_tick),
        .o_bit_tick   (o_bit_tick),
        .o_div_ack    (o_div_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges so far; outputs after edge N are logged at index N
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            s_hist[cyc] <= o_sample_tick;
            m_hist[cyc] <= o_mid_tick;
            b_hist[cyc] <= o_bit_tick;
            a_hist[cyc] <= o_div_ack;
        end
    end

    task automatic chk(input string tag, input int c, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %b expected %b", tag, c, got, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Called at a negedge; the strobe is seen at the next edge, returned in s.
    task automatic drive_sync_load(input logic ld, input int n, input int f, output int s);
        sync     = 1'b1;
        load     = ld;
        div_int  = WIDTH'(n);
        div_frac = FRAC'(f);
        s        = cyc + 1;
        @(negedge clk);
        sync = 1'b0;
        load = 1'b0;
    endtask

    // Phase starts at edge t0 with a cleared accumulator and sc = 0. Tick k lands at
    // t0 + k*n + floor((k-1)*f/2^FRAC); ticks at/after fz_at slip by fz_len; after
    // tick ksw (if nonzero) periods become n2 with no fraction.
    task automatic check_seg(input string tag, input int t0, input int n1, input int f,
                             input int ksw, input int n2, input int fz_at, input int fz_len,
                             input int ack_a, input int ack_b, input int tend);
        int   tq[$];
        int   n1e, n2e, t, idx, sc;
        logic es, em, eb, ea;
        n1e = (n1 <= 1) ? 1 : n1;
        n2e = (n2 <= 1) ? 1 : n2;
        for (int k = 1; k < MAXC; k++) begin
            if (ksw == 0 || k <= ksw) begin
                t = t0 + k * n1e + ((k - 1) * f) / FSCALE;
                if (t >= fz_at) t = t + fz_len;
            end else begin
                t = tq[ksw - 1] + (k - ksw) * n2e;
            end
            if (t > tend) break;
            tq.push_back(t);
        end
        idx = 0;
        sc  = 0;
        for (int c = t0; c <= tend; c++) begin
            es = (idx < tq.size()) && (tq[idx] == c);
            em = es && (sc == OSR / 2 - 1);
            eb = es && (sc == OSR - 1);
            ea = (c == ack_a) || (c == ack_b);
            chk({tag, ".sample"}, c, s_hist[c], es);
            chk({tag, ".mid"},    c, m_hist[c], em);
            chk({tag, ".bit"},    c, b_hist[c], eb);
            chk({tag, ".ack"},    c, a_hist[c], ea);
            if (es) begin
                idx++;
                sc = (sc + 1) % OSR;
            end
        end
    endtask

    initial begin
        int s, r, j, off, l, e, ksw, n, f, ne, fz, tend, span;
        int obs[$];

        rst = 1'b1; en = 1'b0; div_int = '0; div_frac = '0; load = 1'b0; sync = 1'b0;

        // reset held: all outputs low
        repeat (3) begin
            @(negedge clk);
            chk("rst.sample", cyc, o_sample_tick, 1'b0);
            chk("rst.mid",    cyc, o_mid_tick,    1'b0);
            chk("rst.bit",    cyc, o_bit_tick,    1'b0);
            chk("rst.ack",    cyc, o_div_ack,     1'b0);
        end
        rst = 1'b0;
        en  = 1'b1;
        r   = cyc;
        wait_cyc(r + 61);
        check_seg("reset", r, DEF_DIV, 0, 0, 0, NEVER, 0, -1, -1, r + 60);

        // div 4 via load+sync: immediate apply with ack, 64-clock bit
        drive_sync_load(1'b1, 4, 0, s);
        wait_cyc(s + 136);
        check_seg("div4", s, 4, 0, 0, 0, NEVER, 0, s, -1, s + 135);

        // mid-period load of 10 (sometimes preceded by an overwritten load of 6)
        drive_sync_load(1'b0, 0, 0, s);
        j   = $urandom_range(2, 10);
        off = $urandom_range(0, 3);
        l   = s + 4 * j + off;
        ksw = (off == 0) ? j : j + 1;
        if (off >= 2) begin
            wait_cyc(l - 2);
            load = 1'b1; div_int = 16'd6; div_frac = '0;
        end
        wait_cyc(l - 1);
        load = 1'b1; div_int = 16'd10; div_frac = '0;
        wait_cyc(l);
        load = 1'b0;
        tend = s + 4 * ksw + 200;
        wait_cyc(tend + 1);
        check_seg("load10", s, 4, 0, ksw, 10, NEVER, 0, s + 4 * ksw, -1, tend);

        // random divisors, then a resync at an arbitrary phase without a load
        for (int it = 0; it < 3; it++) begin
            n  = (it == 0) ? $urandom_range(0, 1) : $urandom_range(2, 9);
            f  = (it == 2) ? $urandom_range(1, 15) : 0;
            ne = (n <= 1) ? 1 : n;
            repeat ($urandom_range(0, 12)) @(negedge clk);
            drive_sync_load(1'b1, n, f, s);
            tend = s + ne * 36 + 4;
            wait_cyc(tend + 1);
            check_seg("rand_load", s, n, f, 0, 0, NEVER, 0, s, -1, tend);
            repeat ($urandom_range(0, 12)) @(negedge clk);
            drive_sync_load(1'b0, 0, 0, s);
            wait_cyc(tend - (s - (tend - ne * 36 - 4)) + (s - (tend - ne * 36 - 4)) + 1);
            tend = s + ne * 36 + 4;
            wait_cyc(tend + 1);
            check_seg("rand_sync", s, n, f, 0, 0, NEVER, 0, -1, -1, tend);
        end

        // div 3 + 8/16: alternating 3/4 periods, 1024 periods span 3584 clocks
        drive_sync_load(1'b1, 3, 8, s);
        tend = s + 3600;
        wait_cyc(tend + 1);
        check_seg("frac", s, 3, 8, 0, 0, NEVER, 0, s, -1, tend);
        for (int c = s + 1; c <= tend; c++) if (s_hist[c] === 1'b1) obs.push_back(c);
        span = (obs.size() >= 1025) ? obs[1024] - obs[0] : -1;
        n_tests++;
        assert (span === 3584) else begin
            n_fail++;
            $error("FAIL frac.span: observed %0d expected %0d", span, 3584);
        end

        // enable low for 7 cycles with a fractional divisor
        n  = $urandom_range(5, 9);
        f  = $urandom_range(1, 15);
        drive_sync_load(1'b1, n, f, s);
        fz = s + $urandom_range(3, 40);
        wait_cyc(fz - 1);
        en = 1'b0;
        wait_cyc(fz + 6);
        en = 1'b1;
        tend = s + 40 * n;
        wait_cyc(tend + 1);
        check_seg("freeze", s, n, f, 0, 0, fz, 7, s, -1, tend);

        // load while disabled: applied on the next clock, frozen remainder completes
        drive_sync_load(1'b1, 5, 0, s);
        j = $urandom_range(1, 4);
        e = s + 5 * j + 2;
        wait_cyc(e - 1);
        en = 1'b0;
        wait_cyc(e);
        load = 1'b1; div_int = 16'd7; div_frac = '0;
        wait_cyc(e + 1);
        load = 1'b0;
        wait_cyc(e + 3);
        en = 1'b1;
        tend = s + 5 * (j + 1) + 4 + 140;
        wait_cyc(tend + 1);
        check_seg("en_load", s, 5, 0, j + 1, 7, e, 4, s, e + 2, tend);

        // reset with a load pending: no ack, back to the default divisor
        drive_sync_load(1'b1, 6, 0, s);
        j = $urandom_range(1, 4);
        l = s + 6 * j + 3;
        wait_cyc(l - 1);
        load = 1'b1; div_int = 16'd9; div_frac = '0;
        wait_cyc(l);
        load = 1'b0;
        rst  = 1'b1;
        wait_cyc(l + 2);
        rst = 1'b0;
        r   = l + 2;
        wait_cyc(r + 81);
        check_seg("rst_pend", r, DEF_DIV, 0, 0, 0, NEVER, 0, -1, -1, r + 80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/baud_gen.md
BAUD_GEN -- requirements
Module: baud_gen

Interface
REQ-001 Parameter WIDTH, default 16: integer divisor width.
REQ-002 Parameter FRAC, default 4: fractional divisor bits; 0 disables fractional logic.
REQ-003 Parameter OSR, default 16: oversampling ratio, power of two, range 4..32.
REQ-004 Parameter DEF_DIV, default 27: integer divisor active after reset; fraction resets to 0.
REQ-005 i_clk  in  1  sole clock, all state on rising edge.
REQ-006 i_rst  in  1  reset, asynchronous, active-high.
REQ-007 i_en  in  1  enable; low freezes all counters and suppresses ticks.
REQ-008 i_div_int  in  WIDTH  integer part of the sample period, in clocks.
REQ-009 i_div_frac  in  FRAC  fractional part of the sample period, in 1/2^FRAC clocks.
REQ-010 i_div_load  in  1  one-cycle strobe; captures i_div_int/i_div_frac into the shadow register.
REQ-011 i_sync  in  1  one-cycle strobe; realigns phase, e.g. on RX start-bit edge.
REQ-012 o_sample_tick  out  1  one-cycle pulse per sample period.
REQ-013 o_mid_tick  out  1  one-cycle pulse at the centre of each bit.
REQ-014 o_bit_tick  out  1  one-cycle pulse at the end of each bit.
REQ-015 o_div_ack  out  1  one-cycle pulse when the shadow divisor becomes active.

Function
REQ-016 Sample period = div_int + div_frac/2^FRAC clocks on average; each period is div_int or div_int+1 clocks.
REQ-017 Fraction handling: add div_frac to a FRAC-bit accumulator at each period end; carry-out lengthens the next period by exactly one clock.
REQ-018 Active div_int of 0 or 1 is treated as 1; with frac 0, o_sample_tick is high every enabled cycle.
REQ-019 Down-counter loads period-1 and decrements each enabled cycle.
REQ-020 At zero, the counter reloads and a sample tick is produced.
REQ-021 All three tick outputs are registered.
REQ-022 o_sample_tick is asserted in the cycle after the counter reaches 0 while enabled.
REQ-023 Sample counter sc counts 0..OSR-1 on sample ticks and wraps to 0.
REQ-024 o_mid_tick coincides with the sample tick on which sc goes OSR/2-1 to OSR/2.
REQ-025 o_bit_tick coincides with the sample tick on which sc wraps OSR-1 to 0.
REQ-026 Divisor load: the shadow register is applied at the next period end while enabled, or on the next clock if i_en is low.
REQ-027 Repeated i_div_load before application overwrites the shadow register; exactly one o_div_ack follows.
REQ-028 o_div_ack is asserted in the same cycle the new divisor becomes active.
REQ-029 i_sync clears sc and the accumulator, reloads the counter with period-1, and suppresses ticks that cycle.
REQ-030 The first o_mid_tick after i_sync is OSR/2 sample periods later.
REQ-031 i_sync has priority over normal counting.
REQ-032 i_sync together with a pending or simultaneous load applies the new divisor immediately and asserts o_div_ack.
REQ-033 i_sync is honoured regardless of i_en.
REQ-034 Deasserting i_en mid-period freezes the counter, sc and accumulator; reasserting resumes with no lost or extra clocks.

Reset
REQ-035 i_rst sets: active divisor = DEF_DIV/0, shadow = DEF_DIV/0, counter = DEF_DIV-1, accumulator = 0, sc = 0, no load pending.
REQ-036 All outputs are 0 while i_rst is high and in the first cycle after release.
REQ-037 With i_en high from release, the first o_sample_tick occurs DEF_DIV clocks after release.
REQ-038 Reset asserted mid-operation discards any pending load; o_div_ack is not asserted for it.

Structure
REQ-039 Shared package baud_pkg holds DEF_DIV, OSR limits, the clog2 width helper and the standard-rate divisor constants for 50 MHz (9600/115200).
REQ-040 One sub-module, baud_frac_acc: the FRAC-bit accumulator, inputs add/clear/step, output extend flag; it is bypassed when FRAC = 0.

Verification
REQ-041 div_int=4, frac=0, OSR=16 -> sample ticks every 4 clocks; mid_tick every 64 clocks; bit_tick every 64 clocks, 32 clocks after mid_tick.
REQ-042 div_int=3, frac=8 (FRAC=4) -> periods alternate 3,4; 1024 ticks span exactly 3584 clocks.
REQ-043 Load div 10 mid-period with div 4 active -> current period completes at 4; o_div_ack on the next tick; subsequent periods are 10.
REQ-044 i_sync at arbitrary phase -> no tick that cycle; first o_mid_tick exactly 8*div_int clocks later (OSR=16, frac 0).
REQ-045 i_en low for 7 cycles mid-period -> tick delayed by exactly 7 clocks; sc and accumulator unchanged.
REQ-046 i_rst pulse with load pending -> no o_div_ack; period returns to DEF_DIV; first tick DEF_DIV clocks after release.
